// File: rtl/exec_pkg.sv
// Shared constants, FSM encoding and op helpers for the execute stage.
package exec_pkg;

  localparam int DATA_WIDTH_DEF     = 16;
  localparam int REG_ADDR_WIDTH_DEF = 3;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SHL = 3'd5;
  localparam logic [2:0] ALU_SHR = 3'd6;
  localparam logic [2:0] ALU_MUL = 3'd7;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } ex_state_e;

  function automatic logic is_mul(input logic [2:0] op);
    return op == ALU_MUL;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier, low half of the product, DATA_WIDTH cycles start to done.
module seq_multiplier #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] product_lo
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(DATA_WIDTH - 1);

  logic                  busy_q;
  logic                  done_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] acc_q;

  // Bit 0 is folded into the start edge so the last partial sum lands one
  // edge before the consumer registers the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
    end else if (abort) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      a_q    <= a << 1;
      b_q    <= b >> 1;
      acc_q  <= b[0] ? a : '0;
      cnt_q  <= CNT_START;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      acc_q <= acc_q + (b_q[0] ? a_q : '0);
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign busy       = busy_q | done_q;
  assign done       = done_q;
  assign product_lo = acc_q;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, single-cycle ALU and a 16-cycle iterative multiply.
//   state       | meaning
//   ST_IDLE     | accepting instructions; ALU ops complete in one edge
//   ST_MUL_BUSY | multiply iterating; stall_out high, valid_in ignored
module execute_stage
  import exec_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      valid_in,
  input  logic [2:0]                alu_op_in,
  input  logic                      use_imm_in,
  input  logic [DATA_WIDTH-1:0]     imm_in,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_in,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_in,
  input  logic [DATA_WIDTH-1:0]     rs1_data_in,
  input  logic [DATA_WIDTH-1:0]     rs2_data_in,
  input  logic [REG_ADDR_WIDTH-1:0] rd_in,
  input  logic                      reg_write_in,
  input  logic                      wb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] wb_write_reg,
  input  logic [DATA_WIDTH-1:0]     wb_write_data,
  output logic                      stall_out,
  output logic                      valid_out,
  output logic [REG_ADDR_WIDTH-1:0] rd_out,
  output logic [DATA_WIDTH-1:0]     result_out,
  output logic                      reg_write_out
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  ex_state_e                 state_q;
  logic [REG_ADDR_WIDTH-1:0] mul_rd_q;
  logic                      mul_we_q;

  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] rs2_fwd;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  accept;
  logic                  mul_start;
  logic                  mul_busy;
  logic                  mul_done;
  logic [DATA_WIDTH-1:0] mul_product;

  assign stall_out = (state_q == ST_MUL_BUSY);
  assign accept    = valid_in && !stall_out && !flush;
  assign mul_start = accept && is_mul(alu_op_in) && !mul_busy;

  // Own output register beats write-back: it holds the younger value.
  always_comb begin
    op_a = rs1_data_in;
    if (valid_out && reg_write_out && rd_out == rs1_addr_in)
      op_a = result_out;
    else if (wb_reg_write && wb_write_reg == rs1_addr_in)
      op_a = wb_write_data;

    rs2_fwd = rs2_data_in;
    if (valid_out && reg_write_out && rd_out == rs2_addr_in)
      rs2_fwd = result_out;
    else if (wb_reg_write && wb_write_reg == rs2_addr_in)
      rs2_fwd = wb_write_data;

    op_b = use_imm_in ? imm_in : rs2_fwd;
  end

  always_comb begin
    alu_res = '0;
    case (alu_op_in)
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_SHL: alu_res = op_a << op_b[SHAMT_W-1:0];
      ALU_SHR: alu_res = op_a >> op_b[SHAMT_W-1:0];
      default: alu_res = '0;
    endcase
  end

  seq_multiplier #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (mul_start),
    .abort      (flush),
    .a          (op_a),
    .b          (op_b),
    .busy       (mul_busy),
    .done       (mul_done),
    .product_lo (mul_product)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      valid_out     <= 1'b0;
      rd_out        <= '0;
      result_out    <= '0;
      reg_write_out <= 1'b0;
      mul_rd_q      <= '0;
      mul_we_q      <= 1'b0;
    end else if (flush) begin
      state_q       <= ST_IDLE;
      valid_out     <= 1'b0;
      reg_write_out <= 1'b0;
    end else if (state_q == ST_MUL_BUSY && mul_done) begin
      state_q       <= ST_IDLE;
      valid_out     <= 1'b1;
      rd_out        <= mul_rd_q;
      result_out    <= mul_product;
      reg_write_out <= mul_we_q;
    end else if (accept) begin
      if (is_mul(alu_op_in)) begin
        state_q       <= ST_MUL_BUSY;
        mul_rd_q      <= rd_in;
        mul_we_q      <= reg_write_in;
        valid_out     <= 1'b0;
        reg_write_out <= 1'b0;
      end else begin
        valid_out     <= 1'b1;
        rd_out        <= rd_in;
        result_out    <= alu_res;
        reg_write_out <= reg_write_in;
      end
    end else begin
      valid_out     <= 1'b0;
      reg_write_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: vector table plus scoreboard, with hand sequences for multiply, flush and reset.
module tb_execute_stage;
  import exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        valid_in;
  logic [2:0]  alu_op_in;
  logic        use_imm_in;
  logic [15:0] imm_in;
  logic [2:0]  rs1_addr_in, rs2_addr_in;
  logic [15:0] rs1_data_in, rs2_data_in;
  logic [2:0]  rd_in;
  logic        reg_write_in;
  logic        wb_reg_write;
  logic [2:0]  wb_write_reg;
  logic [15:0] wb_write_data;
  logic        stall_out, valid_out, reg_write_out;
  logic [2:0]  rd_out;
  logic [15:0] result_out;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .valid_in(valid_in),
    .alu_op_in(alu_op_in), .use_imm_in(use_imm_in), .imm_in(imm_in),
    .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in),
    .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
    .rd_in(rd_in), .reg_write_in(reg_write_in),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .stall_out(stall_out), .valid_out(valid_out), .rd_out(rd_out),
    .result_out(result_out), .reg_write_out(reg_write_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        use_imm;
    logic [15:0] imm;
    logic [2:0]  rs1a, rs2a;
    logic [15:0] rs1d, rs2d;
    logic [2:0]  rd;
    logic        we;
    logic        wbwe;
    logic [2:0]  wbreg;
    logic [15:0] wbd;
    logic [15:0] exp;
  } vec_t;

  typedef struct packed {
    logic [2:0]  rd;
    logic [15:0] res;
    logic        we;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];
  exp_t e_mon;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] rd, input logic [15:0] res, input logic we);
    exp_t e;
    e.rd = rd; e.res = res; e.we = we;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [2:0] op, input logic ui, input logic [15:0] imm,
                       input logic [2:0] r1a, input logic [15:0] r1d,
                       input logic [2:0] r2a, input logic [15:0] r2d,
                       input logic [2:0] rd, input logic we);
    valid_in = 1'b1; alu_op_in = op; use_imm_in = ui; imm_in = imm;
    rs1_addr_in = r1a; rs1_data_in = r1d; rs2_addr_in = r2a; rs2_data_in = r2d;
    rd_in = rd; reg_write_in = we;
  endtask

  task automatic idle();
    valid_in = 1'b0; flush = 1'b0; alu_op_in = ALU_ADD; use_imm_in = 1'b0; imm_in = '0;
    rs1_addr_in = '0; rs2_addr_in = '0; rs1_data_in = '0; rs2_data_in = '0;
    rd_in = '0; reg_write_in = 1'b0;
    wb_reg_write = 1'b0; wb_write_reg = '0; wb_write_data = '0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (valid_out) begin
        lat = i;
        break;
      end
    end
  endtask

  // Scoreboard: every completed instruction must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && valid_out) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got rd=%0d result=0x%0h expected no output", rd_out, result_out);
      end else begin
        e_mon = sb.pop_front();
        chk("sb_rd", 32'(rd_out), 32'(e_mon.rd));
        chk("sb_result", 32'(result_out), 32'(e_mon.res));
        chk("sb_reg_write", 32'(reg_write_out), 32'(e_mon.we));
      end
    end
  end

  initial begin
    int lat;
    int stall_cnt;
    int saw_valid;

    //               op       ui  imm       r1a r2a r1d       r2d       rd we wbwe wbreg wbd       exp
    vecs[0]  = '{ALU_ADD, 1, 16'h0001, 6, 7, 16'h7FFF, 16'h0000, 5, 1, 0, 0, 16'h0000, 16'h8000};
    vecs[1]  = '{ALU_SUB, 1, 16'h0001, 7, 7, 16'h0000, 16'h0000, 4, 1, 0, 0, 16'h0000, 16'hFFFF};
    vecs[2]  = '{ALU_ADD, 1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000, 16'h0010};
    vecs[3]  = '{ALU_ADD, 0, 16'h0000, 1, 1, 16'h0000, 16'h0000, 2, 1, 0, 0, 16'h0000, 16'h0020};
    vecs[4]  = '{ALU_OR,  1, 16'h0000, 3, 0, 16'h0000, 16'h0000, 3, 1, 1, 3, 16'h1234, 16'h1234};
    vecs[5]  = '{ALU_ADD, 1, 16'h0000, 3, 0, 16'h0000, 16'h0000, 6, 1, 1, 3, 16'h5555, 16'h1234};
    vecs[6]  = '{ALU_XOR, 0, 16'h0000, 7, 2, 16'h00FF, 16'h0000, 0, 1, 1, 2, 16'h0F0F, 16'h0FF0};
    vecs[7]  = '{ALU_AND, 0, 16'h0000, 4, 5, 16'hF0F0, 16'h3C3C, 7, 1, 0, 0, 16'h0000, 16'h3030};
    vecs[8]  = '{ALU_SHL, 1, 16'h0011, 1, 0, 16'h8001, 16'h0000, 1, 1, 0, 0, 16'h0000, 16'h0002};
    vecs[9]  = '{ALU_SHR, 1, 16'h000F, 2, 0, 16'h8000, 16'h0000, 2, 1, 0, 0, 16'h0000, 16'h0001};
    vecs[10] = '{ALU_ADD, 1, 16'h0001, 2, 0, 16'h9999, 16'h0000, 3, 0, 0, 0, 16'h0000, 16'h0002};
    vecs[11] = '{ALU_ADD, 1, 16'h0000, 3, 0, 16'h0100, 16'h0000, 4, 1, 0, 0, 16'h0000, 16'h0100};

    idle();
    rst_n = 1'b0;
    drive(ALU_ADD, 1, 16'h0001, 1, 16'h0005, 0, 0, 2, 1);
    repeat (2) tick();
    chk("rst_valid_out", 32'(valid_out), 0);
    chk("rst_rd_out", 32'(rd_out), 0);
    chk("rst_result_out", 32'(result_out), 0);
    chk("rst_reg_write_out", 32'(reg_write_out), 0);
    chk("rst_stall_out", 32'(stall_out), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].op, vecs[i].use_imm, vecs[i].imm, vecs[i].rs1a, vecs[i].rs1d,
            vecs[i].rs2a, vecs[i].rs2d, vecs[i].rd, vecs[i].we);
      wb_reg_write = vecs[i].wbwe; wb_write_reg = vecs[i].wbreg; wb_write_data = vecs[i].wbd;
      push_exp(vecs[i].rd, vecs[i].exp, vecs[i].we);
      tick();
    end

    idle();
    tick();
    chk("bubble_valid_out", 32'(valid_out), 0);
    chk("bubble_reg_write_out", 32'(reg_write_out), 0);
    chk("bubble_result_hold", 32'(result_out), 32'h0100);
    chk("bubble_rd_hold", 32'(rd_out), 4);

    // After a bubble the stale output register must not forward.
    drive(ALU_ADD, 1, 16'h0000, 4, 16'h0007, 0, 0, 3, 1);
    push_exp(3, 16'h0007, 1);
    tick();

    // MUL with held dependent ADD behind it.
    drive(ALU_MUL, 1, 16'h0010, 0, 16'h0123, 0, 0, 5, 1);
    push_exp(5, 16'h1230, 1);
    tick();
    chk("mul_accept_stall", 32'(stall_out), 1);
    chk("mul_accept_valid", 32'(valid_out), 0);
    drive(ALU_ADD, 1, 16'h0001, 5, 16'h0000, 0, 0, 6, 1);
    push_exp(6, 16'h1231, 1);
    lat = 0;
    stall_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      if (stall_out) stall_cnt++;
      tick();
      if (valid_out) begin
        lat = i;
        break;
      end
    end
    chk("mul_latency", 32'(lat), 16);
    chk("mul_stall_cycles", 32'(stall_cnt), 16);
    chk("mul_stall_released", 32'(stall_out), 0);
    tick();
    idle();
    tick();

    drive(ALU_MUL, 0, 16'h0000, 0, 16'hFFFF, 1, 16'hFFFF, 7, 1);
    push_exp(7, 16'h0001, 1);
    tick();
    idle();
    wait_valid(lat);
    chk("mul_ffff_latency", 32'(lat), 16);

    // Flush five cycles into a multiply, with an incoming instruction killed too.
    drive(ALU_MUL, 1, 16'h0004, 0, 16'h0003, 0, 0, 2, 1);
    tick();
    idle();
    repeat (4) tick();
    drive(ALU_ADD, 1, 16'h0055, 0, 16'h0000, 0, 0, 1, 1);
    flush = 1'b1;
    tick();
    chk("flush_stall", 32'(stall_out), 0);
    chk("flush_valid", 32'(valid_out), 0);
    chk("flush_reg_write", 32'(reg_write_out), 0);
    idle();
    saw_valid = 0;
    repeat (20) begin
      tick();
      if (valid_out) saw_valid++;
    end
    chk("flushed_mul_silent", 32'(saw_valid), 0);
    drive(ALU_SUB, 1, 16'h0003, 1, 16'h0010, 0, 0, 1, 1);
    push_exp(1, 16'h000D, 1);
    tick();
    idle();
    tick();

    // Reset aborts an in-progress multiply.
    drive(ALU_MUL, 1, 16'h0002, 0, 16'h0021, 0, 0, 3, 1);
    tick();
    idle();
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk("rst_abort_stall", 32'(stall_out), 0);
    chk("rst_abort_result", 32'(result_out), 0);
    rst_n = 1'b1;
    saw_valid = 0;
    repeat (20) begin
      tick();
      if (valid_out) saw_valid++;
    end
    chk("rst_aborted_mul_silent", 32'(saw_valid), 0);

    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
